// File: rtl/bid_round_logger.sv
// Logs one record per completed auction round into a show-ahead FIFO and keeps
// saturating per-bidder win counters plus a saturating revenue total.
module bid_round_logger #(
  parameter int DEPTH   = 8,
  parameter int ROUND_W = 8,
  parameter int CNT_W   = 16,
  parameter int REV_W   = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       roundOver,
  input  logic                       X_win,
  input  logic                       Y_win,
  input  logic                       Z_win,
  input  logic [31:0]                maxBid,
  input  logic                       clr_stats,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ROUND_W+33:0]        rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic                       err_multi,
  output logic [CNT_W-1:0]           X_wins,
  output logic [CNT_W-1:0]           Y_wins,
  output logic [CNT_W-1:0]           Z_wins,
  output logic [REV_W-1:0]           revenue
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = ROUND_W + 34;

  logic               round_over_q;
  logic [ROUND_W-1:0] round_id_q, round_id_d;
  logic [RW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d, err_multi_q, err_multi_d;
  logic [CNT_W-1:0]   x_wins_q, x_wins_d, y_wins_q, y_wins_d, z_wins_q, z_wins_d;
  logic [REV_W-1:0]   revenue_q, revenue_d;
  logic [REV_W:0]     rev_sum;
  logic               evt, multi, full_w, pop, push_ok;
  logic [1:0]         code;
  logic [RW-1:0]      rec;

  always_comb begin
    evt   = roundOver & ~round_over_q;
    multi = (X_win & Y_win) | (X_win & Z_win) | (Y_win & Z_win);
    code  = 2'b00;
    if (!multi) begin
      if (X_win)      code = 2'b01;
      else if (Y_win) code = 2'b10;
      else if (Z_win) code = 2'b11;
    end
    rec     = {round_id_q, code, maxBid};
    full_w  = (count_q == CW'(DEPTH));
    pop     = (count_q != '0) & rd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok = evt & (~full_w | pop);
    rev_sum = {1'b0, revenue_q} + (REV_W+1)'(maxBid);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push_ok);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push_ok) - CW'(pop);
    round_id_d  = round_id_q + ROUND_W'(evt);
    overflow_d  = overflow_q | (evt & ~push_ok);
    err_multi_d = err_multi_q | (evt & multi);
    x_wins_d    = x_wins_q;
    y_wins_d    = y_wins_q;
    z_wins_d    = z_wins_q;
    revenue_d   = revenue_q;
    if (evt && code != 2'b00) begin
      if (code == 2'b01 && x_wins_q != '1) x_wins_d = x_wins_q + 1'b1;
      if (code == 2'b10 && y_wins_q != '1) y_wins_d = y_wins_q + 1'b1;
      if (code == 2'b11 && z_wins_q != '1) z_wins_d = z_wins_q + 1'b1;
      revenue_d = rev_sum[REV_W] ? '1 : rev_sum[REV_W-1:0];
    end
    // Clear wins over any coincident event update; the record itself is still logged.
    if (clr_stats) begin
      round_id_d  = '0;
      overflow_d  = 1'b0;
      err_multi_d = 1'b0;
      x_wins_d    = '0;
      y_wins_d    = '0;
      z_wins_d    = '0;
      revenue_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_over_q <= 1'b0;
      round_id_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      err_multi_q  <= 1'b0;
      x_wins_q     <= '0;
      y_wins_q     <= '0;
      z_wins_q     <= '0;
      revenue_q    <= '0;
    end else begin
      round_over_q <= roundOver;
      round_id_q   <= round_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      err_multi_q  <= err_multi_d;
      x_wins_q     <= x_wins_d;
      y_wins_q     <= y_wins_d;
      z_wins_q     <= z_wins_d;
      revenue_q    <= revenue_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rec;
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign err_multi = err_multi_q;
  assign X_wins    = x_wins_q;
  assign Y_wins    = y_wins_q;
  assign Z_wins    = z_wins_q;
  assign revenue   = revenue_q;
endmodule

// File: tb/tb_bid_round_logger.sv
// Directed bench for bid_round_logger: logging, FIFO full/overflow, multi-win
// errors, revenue saturation, stats clear and asynchronous reset.
module tb_bid_round_logger;
  localparam int DEPTH = 8, ROUND_W = 8, CNT_W = 16, REV_W = 33;

  logic clk = 1'b0;
  logic reset, roundOver, X_win, Y_win, Z_win, clr_stats, rd_ready;
  logic [31:0] maxBid;
  logic rd_valid, full, overflow, err_multi;
  logic [ROUND_W+33:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] X_wins, Y_wins, Z_wins;
  logic [REV_W-1:0] revenue;
  int checks = 0, errors = 0;

  bid_round_logger #(.DEPTH(DEPTH), .ROUND_W(ROUND_W), .CNT_W(CNT_W), .REV_W(REV_W)) dut (
    .clk(clk), .reset(reset), .roundOver(roundOver), .X_win(X_win), .Y_win(Y_win),
    .Z_win(Z_win), .maxBid(maxBid), .clr_stats(clr_stats), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .full(full),
    .overflow(overflow), .err_multi(err_multi), .X_wins(X_wins), .Y_wins(Y_wins),
    .Z_wins(Z_wins), .revenue(revenue)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rec(input logic [7:0] id, input logic [1:0] c, input logic [31:0] a);
    return {22'b0, id, c, a};
  endfunction

  task automatic do_round(input logic x, input logic y, input logic z, input logic [31:0] amt);
    roundOver = 1'b1; X_win = x; Y_win = y; Z_win = z; maxBid = amt;
    step(1);
    roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    reset = 1'b1; roundOver = 0; X_win = 0; Y_win = 0; Z_win = 0;
    clr_stats = 0; rd_ready = 0; maxBid = '0;
    step(2);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_rev", 64'(revenue), 64'd0);
    reset = 1'b0;
    step(1);

    // Held roundOver gives one record, visible one cycle after the rise
    roundOver = 1'b1; Y_win = 1'b1; maxBid = 32'h1F4;
    step(1);
    chk("t1_valid", 64'(rd_valid), 64'd1);
    chk("t1_rec", 64'(rd_data), rec(8'd0, 2'b10, 32'h1F4));
    chk("t1_ywins", 64'(Y_wins), 64'd1);
    chk("t1_rev", 64'(revenue), 64'h1F4);
    step(4);
    chk("t1_count_held", 64'(count), 64'd1);
    roundOver = 1'b0; Y_win = 1'b0;
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    chk("t1_drained", 64'(rd_valid), 64'd0);

    // Nine X wins into an eight-deep FIFO
    do_reset();
    for (int n = 1; n <= 9; n++) do_round(1'b1, 1'b0, 1'b0, 32'(n));
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_count", 64'(count), 64'd8);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_xwins", 64'(X_wins), 64'd9);
    chk("t2_rev", 64'(revenue), 64'd45);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_rec", 64'(rd_data), rec(8'(i), 2'b01, 32'(i + 1)));
      step(1);
    end
    rd_ready = 1'b0;
    chk("t2_empty", 64'(count), 64'd0);

    // Full FIFO: event coincident with a pop
    do_reset();
    for (int n = 1; n <= 8; n++) do_round(1'b1, 1'b0, 1'b0, 32'(n));
    chk("t3_full_before", 64'(full), 64'd1);
    rd_ready = 1'b1; roundOver = 1'b1; X_win = 1'b1; maxBid = 32'hAA;
    step(1);
    rd_ready = 1'b0; roundOver = 1'b0; X_win = 1'b0;
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd0);
    chk("t3_head", 64'(rd_data), rec(8'd1, 2'b01, 32'd2));
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("t3_tail", 64'(rd_data), rec(8'd8, 2'b01, 32'hAA));
      step(1);
    end
    rd_ready = 1'b0;
    chk("t3_empty", 64'(rd_valid), 64'd0);

    // Multiple winners: code 00, no stats update
    do_round(1'b1, 1'b0, 1'b1, 32'h64);
    chk("t4_rec", 64'(rd_data), rec(8'd9, 2'b00, 32'h64));
    chk("t4_err", 64'(err_multi), 64'd1);
    chk("t4_xwins", 64'(X_wins), 64'd9);
    chk("t4_zwins", 64'(Z_wins), 64'd0);
    chk("t4_rev", 64'(revenue), 64'd206);
    rd_ready = 1'b1; step(1); rd_ready = 1'b0;

    // Revenue saturation, then clr_stats coincident with an event
    do_reset();
    do_round(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    do_round(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("t5_rev_2", 64'(revenue), 64'h1_FFFF_FFFE);
    do_round(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("t5_rev_sat", 64'(revenue), 64'h1_FFFF_FFFF);
    chk("t5_zwins", 64'(Z_wins), 64'd3);
    do_round(1'b1, 1'b1, 1'b0, 32'h10);
    chk("t5_err", 64'(err_multi), 64'd1);
    roundOver = 1'b1; Y_win = 1'b1; maxBid = 32'd7; clr_stats = 1'b1;
    step(1);
    roundOver = 1'b0; Y_win = 1'b0; clr_stats = 1'b0;
    chk("t5_count", 64'(count), 64'd5);
    chk("t5_rev_clr", 64'(revenue), 64'd0);
    chk("t5_ywins_clr", 64'(Y_wins), 64'd0);
    chk("t5_zwins_clr", 64'(Z_wins), 64'd0);
    chk("t5_err_clr", 64'(err_multi), 64'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t5_clr_rec", 64'(rd_data), rec(8'd4, 2'b10, 32'd7));
      step(1);
    end
    rd_ready = 1'b0;
    do_round(1'b1, 1'b0, 1'b0, 32'd3);
    chk("t5_post_clr_rec", 64'(rd_data), rec(8'd0, 2'b01, 32'd3));
    chk("t5_xwins", 64'(X_wins), 64'd1);

    // Asynchronous reset in the middle of a drain
    do_round(1'b0, 1'b1, 1'b0, 32'd4);
    do_round(1'b0, 1'b0, 1'b1, 32'd5);
    chk("t6_queued", 64'(count), 64'd3);
    rd_ready = 1'b1;
    step(1);
    chk("t6_mid", 64'(count), 64'd2);
    reset = 1'b1;
    #1;
    chk("t6_valid", 64'(rd_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_xwins", 64'(X_wins), 64'd0);
    chk("t6_rev", 64'(revenue), 64'd0);
    reset = 1'b0; rd_ready = 1'b0;
    step(1);
    do_round(1'b1, 1'b0, 1'b0, 32'd9);
    chk("t6_post_rec", 64'(rd_data), rec(8'd0, 2'b01, 32'd9));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
